io_port_unit: RTL

- Execute-stage I/O unit serving the core's input/output instructions.
- Consumes input_en/output_en and operand data from the dispatch→exec pipeline register.
- Produces input_data for the exec→writeback register, and io_stall for the pipeline registers.
- Buffers bytes between the core and an external byte-stream link (UART bridge) in an RX FIFO and a TX FIFO.

---
 rtl/io_port_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/io_port_unit.sv
// Execute-stage I/O unit: RX/TX byte FIFOs between the core's input/output
// instructions and an external byte-stream link.
module io_port_unit #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        stall,
  input  logic                        input_en,
  input  logic                        output_en,
  input  logic                        funct3_0,
  input  logic [31:0]                 wdata,
  output logic [31:0]                 input_data,
  output logic                        io_stall,
  input  logic [7:0]                  rx_byte,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [7:0]                  tx_byte,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        rx_overflow,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic [$clog2(TX_DEPTH):0]   tx_count
);

  localparam int RA  = $clog2(RX_DEPTH);
  localparam int RCW = RA + 1;
  localparam int TA  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [RA-1:0]  rx_wr, rx_rd;
  logic [TA-1:0]  tx_wr, tx_rd;

  logic [RCW-1:0] need;
  logic           rx_short, tx_full, commit;
  logic           rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]     b0, b1, b2, b3;

  assign need     = funct3_0 ? RCW'(4) : RCW'(1);
  assign rx_short = rx_count < need;
  // full is judged on the registered count: a same-cycle link pop does not free a slot
  assign tx_full  = tx_count == TCW'(TX_DEPTH);

  assign io_stall = rstn & ((input_en & rx_short) | (output_en & tx_full));
  assign commit   = rstn & (input_en | output_en) & ~io_stall & ~stall;
  assign rx_pop   = commit & input_en;
  assign tx_push  = commit & output_en;

  assign rx_ready = rstn & (rx_count < RCW'(RX_DEPTH));
  assign rx_push  = rx_valid & rx_ready;
  assign tx_valid = rstn & (tx_count != '0);
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_byte  = tx_mem[tx_rd];

  // little-endian peek; RA-bit adds wrap at the power-of-two depth
  assign b0 = rx_mem[rx_rd];
  assign b1 = rx_mem[rx_rd + RA'(1)];
  assign b2 = rx_mem[rx_rd + RA'(2)];
  assign b3 = rx_mem[rx_rd + RA'(3)];

  always_comb begin
    input_data = '0;
    if (rx_pop)
      input_data = funct3_0 ? {b3, b2, b1, b0} : {24'b0, b0};
  end

  function automatic logic [TA-1:0] tx_inc(input logic [TA-1:0] p);
    return (p == TA'(TX_DEPTH - 1)) ? '0 : p + TA'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_byte;
    if (tx_push) tx_mem[tx_wr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wr       <= '0;
      rx_rd       <= '0;
      rx_count    <= '0;
      tx_wr       <= '0;
      tx_rd       <= '0;
      tx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RA'(1);
      if (rx_pop)  rx_rd <= rx_rd + need[RA-1:0];
      rx_count <= rx_count + RCW'(rx_push) - (rx_pop ? need : RCW'(0));
      if (tx_push) tx_wr <= tx_inc(tx_wr);
      if (tx_pop)  tx_rd <= tx_inc(tx_rd);
      tx_count <= tx_count + TCW'(tx_push) - TCW'(tx_pop);
      if (rx_valid & ~rx_ready) rx_overflow <= 1'b1;
    end
  end

endmodule
